// File: rtl/fetch_pkg.sv
//==============================================================================
// Module   : fetch_pkg
// Desc     : Shared types and constants for the instruction fetch stage:
//            FSM state encoding, instruction width, opcode field positions
//            and the op codes understood by the execute stage.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package fetch_pkg;

    localparam int OPW = 16;

    // Instruction field layout: op | rA | rB | rC | imm
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 13;
    localparam int RA_MSB  = 12;
    localparam int RA_LSB  = 10;
    localparam int RB_MSB  = 9;
    localparam int RB_LSB  = 7;
    localparam int RC_MSB  = 6;
    localparam int RC_LSB  = 4;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_SUBI = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_t;

    function automatic logic [2:0] op_field(input logic [OPW-1:0] word);
        return word[OP_MSB:OP_LSB];
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buf.sv
//==============================================================================
// Module   : fetch_skid_buf
// Desc     : Two-entry valid/ready output buffer with occupancy count. The
//            head entry is presented directly, so the output word stays put
//            until it is accepted.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_skid_buf #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   count
);

    logic [W-1:0] r_entry [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_count;
    logic         w_pop;

    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_entry[r_rptr];
    assign count     = r_count;
    assign w_pop     = out_valid && out_ready;

    // Entry storage, pointers and occupancy; the producer never pushes when full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entry[0] <= '0;
            r_entry[1] <= '0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            if (push) begin
                r_entry[r_wptr] <= push_data;
                r_wptr          <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, push} - {1'b0, w_pop};
        end
    end

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
//==============================================================================
// Module   : instr_fetch
// Desc     : Instruction fetch stage. Holds a writable program memory and a
//            program counter; after start, streams words 0..end_addr to the
//            execute stage over valid/ready through a 2-entry buffer.
// Options  : INSTR_FETCH_LOOP_EN - wrap from end_addr back to address 0 and
//            run until stop instead of ending after end_addr.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module instr_fetch #(
    parameter int ADDR_W = 4,
    parameter int OPW    = fetch_pkg::OPW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [OPW-1:0]    wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [OPW-1:0]    opcode_out,
    output logic              opcode_valid,
    input  logic              opcode_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done
);

    import fetch_pkg::*;

    localparam int DEPTH = 2 ** ADDR_W;

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_end_addr;
    logic [OPW-1:0]    r_mem [DEPTH];
    logic [1:0]        w_count;
    logic              w_idle_like;
    logic              w_start_ok;
    logic              w_issue;
    logic              w_at_end;
    logic              w_pop;

    // Writes and start are only honoured when no run is active
    assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_start_ok  = start && w_idle_like;
    // Issue only while the buffer can absorb the word arriving next edge
    assign w_issue     = (r_state == ST_FETCH) && (w_count < 2'd2);
    assign w_at_end    = (r_pc == r_end_addr);
    assign w_pop       = opcode_valid && opcode_ready;
    assign pc          = r_pc;

    // Program memory write port (not reset)
    always_ff @(posedge clk) begin
        if (wr_en && w_idle_like) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and status outputs
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                busy = 1'b1;
`ifdef INSTR_FETCH_LOOP_EN
                if (stop) w_state_next = ST_DRAIN;
`else
                if (stop || (w_issue && w_at_end)) w_state_next = ST_DRAIN;
`endif
            end
            ST_DRAIN: begin
                busy = 1'b1;
                // Finish once the buffer is empty after this cycle's transfer
                if ((w_count == 2'd0) || ((w_count == 2'd1) && w_pop)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) w_state_next = ST_FETCH;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Program counter and latched end address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= '0;
            r_end_addr <= '0;
        end else if (w_start_ok) begin
            r_pc       <= '0;
            r_end_addr <= end_addr;
        end else if (w_issue) begin
`ifdef INSTR_FETCH_LOOP_EN
            r_pc <= w_at_end ? '0 : r_pc + 1'b1;
`else
            r_pc <= r_pc + 1'b1;
`endif
        end
    end

    // The buffer entry register doubles as the synchronous memory read register
    fetch_skid_buf #(
        .W (OPW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_issue),
        .push_data (r_mem[r_pc]),
        .out_data  (opcode_out),
        .out_valid (opcode_valid),
        .out_ready (opcode_ready),
        .count     (w_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
//==============================================================================
// Module   : tb_instr_fetch
// Desc     : Self-checking bench for instr_fetch. A behavioural model builds
//            the expected word stream from a shadow copy of program memory;
//            a monitor compares every transfer and the hold rule.
// Options  : INSTR_FETCH_LOOP_EN - exercises wrap-around runs ended by stop.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_instr_fetch;

    localparam int ADDR_W = 4;
    localparam int OPW    = 16;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [OPW-1:0]    wr_data;
    logic              start;
    logic              stop;
    logic [ADDR_W-1:0] end_addr;
    logic [OPW-1:0]    opcode_out;
    logic              opcode_valid;
    logic              opcode_ready;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              done;

    int n_chk = 0;
    int n_err = 0;

    logic [OPW-1:0] model_mem [DEPTH];
    logic [OPW-1:0] exp_q [$];

    logic           mon_prev_valid = 1'b0;
    logic           mon_prev_ready = 1'b0;
    logic [OPW-1:0] mon_prev_out   = '0;

    logic [OPW-1:0]    obs_out   [64];
    logic              obs_valid [64];
    logic              obs_busy  [64];
    logic              obs_done  [64];
    logic [ADDR_W-1:0] obs_pc    [64];
    int                done_cyc;

    always #5 clk = ~clk;

    instr_fetch #(
        .ADDR_W (ADDR_W),
        .OPW    (OPW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .start        (start),
        .stop         (stop),
        .end_addr     (end_addr),
        .opcode_out   (opcode_out),
        .opcode_valid (opcode_valid),
        .opcode_ready (opcode_ready),
        .pc           (pc),
        .busy         (busy),
        .done         (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transfer monitor: every accepted word must be the next expected one,
    // and a stalled word must stay valid and unchanged.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_prev_valid <= 1'b0;
            mon_prev_ready <= 1'b0;
        end else begin
            if (mon_prev_valid && !mon_prev_ready) begin
                check("hold_valid", 32'(opcode_valid), 32'd1);
                check("hold_data", 32'(opcode_out), 32'(mon_prev_out));
            end
            if (opcode_valid && opcode_ready) begin
                if (exp_q.size() == 0)
                    check("unexpected_word_pending", 32'(exp_q.size()), 32'd1);
                else
                    check("word", 32'(opcode_out), 32'(exp_q.pop_front()));
            end
            mon_prev_valid <= opcode_valid;
            mon_prev_ready <= opcode_ready;
            mon_prev_out   <= opcode_out;
        end
    end

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [OPW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk); #1;
        wr_en   = 1'b0;
        model_mem[a] = d;
    endtask

    // Expected stream for a run that ends after end address e
    task automatic load_exp(input int e);
        exp_q.delete();
        for (int i = 0; i <= e; i++) exp_q.push_back(model_mem[i]);
    endtask

    // Drives one run starting now (just after a rising edge) and records the
    // first 64 cycles. mode: 0 ready high, 1 ready low on cycles 2..6,
    // 2 random ready. A negative cycle number disables that stimulus.
    task automatic run(input int mode, input int endv, input int stop_cyc,
                       input int wr_cyc, input logic [ADDR_W-1:0] wa,
                       input logic [OPW-1:0] wd, input int restart_cyc,
                       input int max_cyc);
        done_cyc = -1;
        for (int i = 0; i < 64; i++) begin
            obs_out[i] = '0; obs_valid[i] = 1'b0; obs_busy[i] = 1'b0;
            obs_done[i] = 1'b0; obs_pc[i] = '0;
        end
        for (int c = 0; c < max_cyc; c++) begin
            start    = (c == 0) || (c == restart_cyc);
            stop     = (c == stop_cyc);
            wr_en    = (c == wr_cyc);
            wr_addr  = wa;
            wr_data  = wd;
            end_addr = (c == 0) ? ADDR_W'(endv) : ADDR_W'($urandom);
            case (mode)
                0:       opcode_ready = 1'b1;
                1:       opcode_ready = !(c >= 2 && c <= 6);
                default: opcode_ready = ($urandom_range(0, 3) != 0);
            endcase
            @(negedge clk);
            if (c < 64) begin
                obs_out[c] = opcode_out; obs_valid[c] = opcode_valid;
                obs_busy[c] = busy; obs_done[c] = done; obs_pc[c] = pc;
            end
            if (c > 0 && done) begin
                done_cyc = c;
                check("busy_at_done", 32'(busy), 32'd0);
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; stop = 1'b0; wr_en = 1'b0; opcode_ready = 1'b1;
        if (done_cyc < 0) check("run_timeout_done_seen", 32'(done), 32'd1);
        @(posedge clk); #1;
        check("all_words_delivered_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OPW-1:0] prog [4];
        logic [OPW-1:0] nw;
        int             s;
        int             e;
        prog[0] = 16'h0050; prog[1] = 16'h2081; prog[2] = 16'h4081; prog[3] = 16'h60A0;

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0; end_addr = '0; opcode_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(opcode_valid), 32'd0);
        check("rst_out", 32'(opcode_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < DEPTH; i++) write_word(ADDR_W'(i), 16'($urandom));
        for (int i = 0; i < 4; i++) write_word(ADDR_W'(i), prog[i]);

`ifdef INSTR_FETCH_LOOP_EN
        // Wrap between addresses 0 and 1; stop on the fifth transfer cycle
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(model_mem[i % 2]);
        run(0, 1, 6, -1, '0, '0, -1, 60);
        check("loop_done_cyc", 32'(done_cyc), 32'd8);

        // Random loop lengths and stop points at full rate
        for (int it = 0; it < 4; it++) begin
            e = $urandom_range(0, 15);
            s = $urandom_range(1, 20);
            exp_q.delete();
            for (int i = 0; i < s; i++) exp_q.push_back(model_mem[i % (e + 1)]);
            run(0, e, s, -1, '0, '0, -1, 80);
            check("loop_rand_done_cyc", 32'(done_cyc), 32'(s + 2));
        end
`else
        // Full-rate program
        load_exp(3);
        run(0, 3, -1, -1, '0, '0, -1, 40);
        check("full_done_cyc", 32'(done_cyc), 32'd6);
        check("full_valid_c1", 32'(obs_valid[1]), 32'd0);
        check("full_pc_c1", 32'(obs_pc[1]), 32'd0);
        for (int c = 2; c <= 5; c++) begin
            check("full_valid", 32'(obs_valid[c]), 32'd1);
            check("full_word_at_cycle", 32'(obs_out[c]), 32'(prog[c - 2]));
        end
        check("full_busy_c5", 32'(obs_busy[5]), 32'd1);
        check("full_done_c5", 32'(obs_done[5]), 32'd0);

        // Backpressure on cycles 2..6
        load_exp(3);
        run(1, 3, -1, -1, '0, '0, -1, 60);
        for (int c = 2; c <= 6; c++) check("bp_stalled_word", 32'(obs_out[c]), 32'h0050);
        check("bp_pc_c3", 32'(obs_pc[3]), 32'd2);
        check("bp_pc_c6", 32'(obs_pc[6]), 32'd2);
        check("bp_done_cyc", 32'(done_cyc), 32'd11);

        // Early stop on cycle 3 with the end address at the top of memory
        load_exp(2);
        run(0, 15, 3, -1, '0, '0, -1, 60);
        check("stop_done_cyc", 32'(done_cyc), 32'd5);

        // Write and start during FETCH are both ignored
        nw = ~model_mem[0];
        load_exp(3);
        run(0, 3, -1, 2, '0, nw, 3, 60);
        check("ign_done_cyc", 32'(done_cyc), 32'd6);
        load_exp(3);
        run(0, 3, -1, -1, '0, '0, -1, 60);
        check("ign_mem0_kept", 32'(obs_out[2]), 32'(prog[0]));

        // Write in the same cycle as start reaches the first fetch
        nw = 16'($urandom);
        model_mem[0] = nw;
        load_exp(3);
        run(0, 3, -1, 0, '0, nw, -1, 60);
        check("wrstart_first_word", 32'(obs_out[2]), 32'(nw));

        // Reset mid-run with the buffer full
        exp_q.delete();
        end_addr = 4'd3; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; opcode_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("prerst_valid", 32'(opcode_valid), 32'd1);
        check("prerst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(opcode_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_pc", 32'(pc), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; opcode_ready = 1'b1;
        @(posedge clk); #1;
        load_exp(3);
        run(0, 3, -1, -1, '0, '0, -1, 60);
        check("postrst_first_word", 32'(obs_out[2]), 32'(model_mem[0]));
        check("postrst_done_cyc", 32'(done_cyc), 32'd6);

        // Randomized programs, end addresses and backpressure
        for (int it = 0; it < 6; it++) begin
            s = $urandom_range(1, 8);
            for (int k = 0; k < s; k++) write_word(ADDR_W'($urandom), 16'($urandom));
            e = (it == 0) ? 0 : $urandom_range(0, 15);
            load_exp(e);
            run((it == 0) ? 0 : 2, e, -1, -1, '0, '0, -1, 400);
            if (it == 0) check("single_word_done_cyc", 32'(done_cyc), 32'd3);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
